// File: rtl/cla_pipe_add.sv
// cla_pipe_add: pipelined two's-complement adder/subtractor, valid/ready stream.
//
// The WIDTH-bit carry chain is cut into STAGES segments of SEG = WIDTH/STAGES
// bits. Stage k adds segment k using the carry registered by stage k-1. The
// upper operand bits travel alongside (skew) and the finished low result bits
// are carried forward (deskew), so the full result leaves the last stage at once.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready = ~out_valid | out_ready
//   a, b, sub           operands; sub=1 computes a-b (b inverted, carry-in 1)
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
//
// Build option
//   ADD_SAT_EN  when defined, sum is clamped to the signed range on overflow
//               in the final stage; cout/ovf still report the unclamped flags.
module cla_pipe_add #(
  parameter int WIDTH  = 20,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("cla_pipe_add: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

`ifdef ADD_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             adv;
  logic [WIDTH-1:0] bx;

  // Whole pipeline moves in lockstep; stalls only when the output is blocked.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bx       = b ^ {WIDTH{sub}};

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - (k + 1) * SEG;

    logic [SEG-1:0]       sa, sb, s;
    logic [SEG:0]         c;
    logic                 ci, vi;
    logic [(k+1)*SEG-1:0] res_raw, res_d, res_q;
    logic                 c_q, v_q;

    if (k == 0) begin : g_src
      assign sa      = a[SEG-1:0];
      assign sb      = bx[SEG-1:0];
      assign ci      = sub;
      assign vi      = in_valid;
      assign res_raw = s;
    end else begin : g_src
      assign sa      = g_stg[k-1].g_op.a_q[SEG-1:0];
      assign sb      = g_stg[k-1].g_op.b_q[SEG-1:0];
      assign ci      = g_stg[k-1].c_q;
      assign vi      = g_stg[k-1].v_q;
      assign res_raw = {s, g_stg[k-1].res_q};
    end

    // Segment chain: generate/propagate ripple, entirely between two registers.
    always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
        c[i+1] = (sa[i] & sb[i]) | ((sa[i] ^ sb[i]) & c[i]);
        s[i]   = sa[i] ^ sb[i] ^ c[i];
      end
    end

    if (k < STAGES - 1) begin : g_op
      // Not-yet-added operand bits, delayed one more stage.
      logic [REM-1:0] a_q, b_q;
      if (k == 0) begin : g_fwd
        always_ff @(posedge clk) begin
          if (adv) begin
            a_q <= a[WIDTH-1:SEG];
            b_q <= bx[WIDTH-1:SEG];
          end
        end
      end else begin : g_fwd
        always_ff @(posedge clk) begin
          if (adv) begin
            a_q <= g_stg[k-1].g_op.a_q[REM+SEG-1:SEG];
            b_q <= g_stg[k-1].g_op.b_q[REM+SEG-1:SEG];
          end
        end
      end
      assign res_d = res_raw;
    end else begin : g_last
      logic ovf_d, ovf_q;
      // Carry into the MSB is c[SEG-1] of the top segment.
      assign ovf_d = c[SEG-1] ^ c[SEG];
`ifdef ADD_SAT_EN
      // cout=1 on overflow means two negatives wrapped positive.
      assign res_d = ovf_d ? (c[SEG] ? SMIN : SMAX) : res_raw;
`else
      assign res_d = res_raw;
`endif
      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= vi;
        c_q   <= c[SEG];
        res_q <= res_d;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].res_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_add.sv
// Bench for cla_pipe_add: one 20-bit/2-stage instance for the directed table
// and corner sequences, plus 32-bit instances with 1, 4 and 8 stages that share
// the same stimulus. Each instance has its own expected-result queue.
module tb_cla_pipe_add;

  localparam int SL[3] = '{1, 4, 8};
`ifdef ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic        sub;
    logic [19:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, iv, ordy, sb;
  logic [31:0] a, b;

  logic        ir20, ov20, co20, of20;
  logic [19:0] s20;
  logic        ir32[3], ov32[3], co32[3], of32[3];
  logic [31:0] s32[3];

  exp_t q[4][$];
  int   rcv[4];
  int   checks = 0, errors = 0, cyc = 0;
  bit   tab_mode = 1'b0, check_lat = 1'b0;
  exp_t tab_exp;
  vec_t tab[10];

  always #5 clk = ~clk;

  cla_pipe_add #(.WIDTH(20), .STAGES(2)) u_d20 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir20),
    .a(a[19:0]), .b(b[19:0]), .sub(sb),
    .out_valid(ov20), .out_ready(ordy), .sum(s20), .cout(co20), .ovf(of20)
  );

  for (genvar g = 0; g < 3; g++) begin : g_d32
    cla_pipe_add #(.WIDTH(32), .STAGES(SL[g])) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir32[g]),
      .a(a), .b(b), .sub(sb),
      .out_valid(ov32[g]), .out_ready(ordy), .sum(s32[g]), .cout(co32[g]), .ovf(of32[g])
    );
  end

  function automatic exp_t model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                 input logic s);
    longint unsigned mask, hmask, aa, bxx, full, low;
    exp_t r;
    mask  = (64'd1 << w) - 64'd1;
    hmask = mask >> 1;
    aa    = {32'b0, ai} & mask;
    bxx   = (s ? ~{32'b0, bi} : {32'b0, bi}) & mask;
    full  = aa + bxx + {63'b0, s};
    low   = (aa & hmask) + (bxx & hmask) + {63'b0, s};
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = low[w-1] ^ r.cout;
    if (SAT && r.ovf) r.sum = r.cout ? (32'd1 << (w-1)) : ((32'd1 << (w-1)) - 32'd1);
    r.cyc = 0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic score(input int id, input int w, input int lat, input logic ir, input logic ov,
                       input logic [31:0] s, input logic co, input logic of);
    exp_t e, m;
    if (rst) begin
      q[id].delete();
      return;
    end
    if (ov && ordy) begin
      checks++;
      if (q[id].size() == 0) begin
        errors++;
        $display("FAIL spurious_out dut%0d: got sum=%h with nothing expected (cycle %0d)", id, s, cyc);
      end else begin
        e = q[id].pop_front();
        rcv[id]++;
        if (s !== e.sum || co !== e.cout || of !== e.ovf) begin
          errors++;
          $display("FAIL result dut%0d: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                   id, s, co, of, e.sum, e.cout, e.ovf);
        end
        if (check_lat) begin
          checks++;
          if (cyc - e.cyc != lat) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d required %0d", id, cyc - e.cyc, lat);
          end
        end
      end
    end
    if (iv && ir) begin
      m = model(w, a, b, sb);
      if (id == 0 && tab_mode) m = tab_exp;
      m.cyc = cyc;
      q[id].push_back(m);
    end
  endtask

  // Inputs are set just after a falling edge; this settles, scores, and moves on.
  task automatic cycle();
    #1;
    score(0, 20, 2, ir20, ov20, {12'b0, s20}, co20, of20);
    for (int g = 0; g < 3; g++) score(g + 1, 32, SL[g], ir32[g], ov32[g], s32[g], co32[g], of32[g]);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int pend;
    iv   = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < budget; i++) begin
      pend = q[0].size() + q[1].size() + q[2].size() + q[3].size();
      if (pend == 0) break;
      cycle();
    end
    pend = q[0].size() + q[1].size() + q[2].size() + q[3].size();
    chk("drain_pending", pend, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, r20;
    logic acc;
    logic [19:0] held;

    tab[0] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0};
    tab[1] = '{20'h00000, 20'h00001, 1'b1, 20'hFFFFF, 1'b0, 1'b0};
    tab[2] = '{20'h12345, 20'h02345, 1'b1, 20'h10000, 1'b1, 1'b0};
    tab[3] = '{20'h7FFFF, 20'h00001, 1'b0, SAT ? 20'h7FFFF : 20'h80000, 1'b0, 1'b1};
    tab[4] = '{20'h80000, 20'h00001, 1'b1, SAT ? 20'h80000 : 20'h7FFFF, 1'b1, 1'b1};
    tab[5] = '{20'h0F0F0, 20'h010F0, 1'b0, 20'h101E0, 1'b0, 1'b0};
    tab[6] = '{20'h003FF, 20'h00001, 1'b0, 20'h00400, 1'b0, 1'b0};
    tab[7] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'h00000, 1'b1, 1'b0};
    tab[8] = '{20'h80000, 20'h80000, 1'b0, SAT ? 20'h80000 : 20'h00000, 1'b1, 1'b1};
    tab[9] = '{20'h00005, 20'h0000A, 1'b1, 20'hFFFFB, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) rcv[i] = 0;

    // Reset state
    rst = 1'b1; iv = 1'b0; ordy = 1'b0; sb = 1'b0; a = '0; b = '0;
    cycle();
    cycle();
    chk("rst_out_valid", {31'b0, ov20}, 0);
    chk("rst_sum", {12'b0, s20}, 0);
    chk("rst_cout", {31'b0, co20}, 0);
    chk("rst_ovf", {31'b0, of20}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, ir20}, 1);
    for (int g = 0; g < 3; g++) chk("rst_out_valid32", {31'b0, ov32[g]}, 0);

    // Directed table, streamed back-to-back with latency checking
    ordy = 1'b1; check_lat = 1'b1; tab_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = {12'b0, tab[i].a}; b = {12'b0, tab[i].b}; sb = tab[i].sub;
      tab_exp = '{sum: {12'b0, tab[i].sum}, cout: tab[i].cout, ovf: tab[i].ovf, cyc: 0};
      iv = 1'b1;
      cycle();
    end
    tab_mode = 1'b0;
    drain(20);
    chk("table_count", rcv[0], 10);

    // 8-beat stream with a 3-cycle output stall in the middle
    check_lat = 1'b0;
    r20 = rcv[0];
    sent = 0;
    held = '0;
    for (int t = 0; t < 40 && sent < 8; t++) begin
      ordy = !(t >= 4 && t < 7);
      iv = 1'b1;
      a = $urandom; b = $urandom; sb = t[0];
      #1;
      if (t == 4) begin
        chk("stall_out_valid", {31'b0, ov20}, 1);
        held = s20;
      end
      if (!ordy) chk("stall_in_ready", {31'b0, ir20}, 0);
      if (t == 5 || t == 6) chk("stall_sum_hold", {12'b0, s20}, {12'b0, held});
      acc = iv & ir20;
      cycle();
      if (acc) sent++;
    end
    chk("stall_sent", sent, 8);
    drain(30);
    chk("stall_count", rcv[0] - r20, 8);

    // Reset with two beats in flight
    r20 = rcv[0];
    ordy = 1'b0; iv = 1'b1;
    a = 32'h0001_1111; b = 32'h0000_2222; sb = 1'b0;
    cycle();
    a = 32'h0003_3333; b = 32'h0000_0444; sb = 1'b1;
    cycle();
    iv = 1'b0;
    #1;
    chk("inflight_out_valid", {31'b0, ov20}, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", {31'b0, ov20}, 0);
    for (int g = 0; g < 3; g++) chk("post_rst_out_valid32", {31'b0, ov32[g]}, 0);
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("post_rst_no_emit", rcv[0] - r20, 0);
    check_lat = 1'b1;
    iv = 1'b1; a = 32'h000A_BCDE; b = 32'h0001_2345; sb = 1'b0;
    cycle();
    drain(20);
    chk("post_rst_new_beat", rcv[0] - r20, 1);

    // Random, out_ready always high: exact latency
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; sb = $urandom_range(0, 1);
      cycle();
    end
    drain(30);

    // Random with backpressure
    check_lat = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; sb = $urandom_range(0, 1);
      cycle();
    end
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
